// File: rtl/pic10_ctrl_seq.sv
// PIC10 instruction sequencer: fetches from ROM, drives the ALU operands and
// commits ALU results to W or the RAM file at the end of each 4-clock Q-cycle.
module pic10_ctrl_seq #(
  parameter int unsigned     PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [PC_W-1:0] rom_addr,
  input  logic [11:0]     rom_data,
  output logic [11:0]     ir_reg_bus,
  output logic [7:0]      w_reg_bus,
  input  logic [7:0]      ram_data_bus,
  output logic [4:0]      ram_addr,
  input  logic [7:0]      alu_bus,
  output logic [7:0]      ram_wr_data,
  output logic            ram_we,
  output logic [1:0]      q_state,
  output logic            illegal_op
);

  localparam int unsigned IR_W = 12;
  localparam int unsigned W_W  = 8;
  localparam int unsigned F_W  = 5;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } q_e;

  q_e              q, q_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [IR_W-1:0] ir, ir_nxt;
  logic [W_W-1:0]  w, w_nxt;

  logic dec_wr_w, dec_wr_ram, dec_skip_clr, dec_skip_set, dec_goto, dec_ill;
  logic test_bit, skip;

  // Instruction decode into writeback destination / PC redirect class
  always_comb begin
    dec_wr_w     = 1'b0;
    dec_wr_ram   = 1'b0;
    dec_skip_clr = 1'b0;
    dec_skip_set = 1'b0;
    dec_goto     = 1'b0;
    dec_ill      = 1'b0;
    unique case (ir[11:10])
      2'b00: begin
        if (ir[9:5] == 5'b00000) begin
          if (ir[4:3] == 2'b00) dec_ill = (ir[2:0] != 3'b000);
          else                  dec_wr_w = 1'b1;
        end else if (ir[9:5] == 5'b00001) begin
          dec_wr_ram = 1'b1;
        end else if (ir[9:5] == 5'b00010) begin
          if (ir[4:0] == 5'b00000) dec_wr_w = 1'b1;
          else                     dec_ill  = 1'b1;
        end else if (ir[9:5] == 5'b00011) begin
          dec_wr_ram = 1'b1;
        end else if (ir[5]) begin
          dec_wr_ram = 1'b1;
        end else begin
          dec_wr_w = 1'b1;
        end
      end
      2'b01: begin
        unique case (ir[9:8])
          2'b00, 2'b01: dec_wr_ram   = 1'b1;
          2'b10:        dec_skip_clr = 1'b1;
          2'b11:        dec_skip_set = 1'b1;
        endcase
      end
      2'b10: begin
        if (ir[9]) dec_goto = 1'b1;
        else       dec_ill  = 1'b1;
      end
      2'b11: dec_wr_w = 1'b1;
    endcase
  end

  assign test_bit = ram_data_bus[ir[7:5]];
  assign skip     = (dec_skip_clr & ~test_bit) | (dec_skip_set & test_bit);

  // Phase sequencing, fetch in Q1, commit in Q4
  always_comb begin
    q_nxt  = q;
    pc_nxt = pc;
    ir_nxt = ir;
    w_nxt  = w;
    unique case (q)
      Q1: begin
        if (en) begin
          ir_nxt = rom_data;
          pc_nxt = pc + PC_W'(1);
          q_nxt  = Q2;
        end
      end
      Q2: q_nxt = Q3;
      Q3: q_nxt = Q4;
      Q4: begin
        q_nxt = Q1;
        if (dec_wr_w) w_nxt = alu_bus;
        if (dec_goto)  pc_nxt = PC_W'(ir[8:0]);
        else if (skip) pc_nxt = pc + PC_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= Q1;
      pc <= RESET_VEC;
      ir <= '0;
      w  <= '0;
    end else begin
      q  <= q_nxt;
      pc <= pc_nxt;
      ir <= ir_nxt;
      w  <= w_nxt;
    end
  end

  // Strobes are decodes of registered state, so they are clean for the whole Q4
  assign ram_we      = (q == Q4) & dec_wr_ram;
  assign illegal_op  = (q == Q4) & dec_ill;
  assign rom_addr    = pc;
  assign ir_reg_bus  = ir;
  assign w_reg_bus   = w;
  assign ram_addr    = ir[F_W-1:0];
  assign ram_wr_data = alu_bus;
  assign q_state     = q;

endmodule

// File: tb/tb_pic10_ctrl_seq.sv
// Bench for pic10_ctrl_seq: ROM/RAM/ALU environment, an instruction-level
// reference model compared every cycle, and directed literal checkpoints.
module tb_pic10_ctrl_seq;

  localparam int K_NOP = 0, K_W = 1, K_RAM = 2, K_SKC = 3, K_SKS = 4, K_GOTO = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data, ir_reg_bus;
  logic [7:0]  w_reg_bus, ram_data_bus, alu_bus, ram_wr_data;
  logic [4:0]  ram_addr;
  logic        ram_we, illegal_op;
  logic [1:0]  q_state;

  logic [11:0] rom     [512];
  logic [7:0]  env_ram [32];
  logic [7:0]  mram    [32];

  int          mq;
  logic [8:0]  mpc;
  logic [11:0] mir;
  logic [7:0]  mw;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  pic10_ctrl_seq #(.PC_W(9), .RESET_VEC(9'h000)) dut (
    .clk(clk), .rst(rst), .en(en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ir_reg_bus(ir_reg_bus), .w_reg_bus(w_reg_bus),
    .ram_data_bus(ram_data_bus), .ram_addr(ram_addr),
    .alu_bus(alu_bus), .ram_wr_data(ram_wr_data), .ram_we(ram_we),
    .q_state(q_state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Small PIC10-flavoured ALU
  function automatic logic [7:0] alu_f(input logic [11:0] i, input logic [7:0] w, input logic [7:0] f);
    logic [7:0] k;
    logic [7:0] r;
    k = i[7:0];
    casez (i)
      12'b0000_001?_????: r = w;
      12'b0000_01??_????: r = 8'h00;
      12'b0001_11??_????: r = w + f;
      12'b0001_01??_????: r = w & f;
      12'b0001_00??_????: r = w | f;
      12'b0001_10??_????: r = w ^ f;
      12'b0010_10??_????: r = f + 8'd1;
      12'b0100_????_????: r = f & ~(8'h01 << i[7:5]);
      12'b0101_????_????: r = f | (8'h01 << i[7:5]);
      12'b1100_????_????: r = k;
      12'b1101_????_????: r = w | k;
      12'b1110_????_????: r = w & k;
      12'b1111_????_????: r = w ^ k;
      default:            r = f;
    endcase
    return r;
  endfunction

  // Instruction classes from the opcode table (first match wins)
  function automatic int kind_f(input logic [11:0] i);
    int k;
    casez (i)
      12'h000:            k = K_NOP;
      12'b0000_0000_0???: k = K_ILL;
      12'b0000_001?_????: k = K_RAM;
      12'b0000_0100_0000: k = K_W;
      12'b0000_010?_????: k = K_ILL;
      12'b0000_011?_????: k = K_RAM;
      12'b00??_??0?_????: k = K_W;
      12'b00??_??1?_????: k = K_RAM;
      12'b010?_????_????: k = K_RAM;
      12'b0110_????_????: k = K_SKC;
      12'b0111_????_????: k = K_SKS;
      12'b101?_????_????: k = K_GOTO;
      12'b100?_????_????: k = K_ILL;
      default:            k = K_W;
    endcase
    return k;
  endfunction

  assign rom_data     = rom[rom_addr];
  assign ram_data_bus = env_ram[ram_addr];
  assign alu_bus      = alu_f(ir_reg_bus, w_reg_bus, ram_data_bus);

  always @(posedge clk) if (ram_we) env_ram[ram_addr] <= ram_wr_data;

  // Reference model: one instruction every four enabled phases
  always @(posedge clk) begin
    int k;
    logic [7:0] f, a;
    if (rst) begin
      mq = 0; mpc = 9'h000; mir = 12'h000; mw = 8'h00;
    end else begin
      case (mq)
        0: if (en) begin mir = rom[mpc]; mpc = mpc + 9'd1; mq = 1; end
        1, 2: mq = mq + 1;
        default: begin
          k = kind_f(mir);
          f = mram[mir[4:0]];
          a = alu_f(mir, mw, f);
          if (k == K_W)   mw = a;
          if (k == K_RAM) mram[mir[4:0]] = a;
          if (k == K_GOTO) mpc = mir[8:0];
          if ((k == K_SKC && !f[mir[7:5]]) || (k == K_SKS && f[mir[7:5]])) mpc = mpc + 9'd1;
          mq = 0;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int k;
      k = kind_f(mir);
      chk("q_state", 32'(q_state), 32'(mq));
      chk("rom_addr", 32'(rom_addr), 32'(mpc));
      chk("ir", 32'(ir_reg_bus), 32'(mir));
      chk("w", 32'(w_reg_bus), 32'(mw));
      chk("ram_addr", 32'(ram_addr), 32'(mir[4:0]));
      chk("ram_we", 32'(ram_we), 32'(mq == 3 && k == K_RAM));
      chk("illegal_op", 32'(illegal_op), 32'(mq == 3 && k == K_ILL));
      if (mq == 3 && k == K_RAM)
        chk("ram_wr_data", 32'(ram_wr_data), 32'(alu_f(mir, mw, mram[mir[4:0]])));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_for(input logic [11:0] irv, input logic [1:0] qv, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      hit = (ir_reg_bus == irv) && (q_state == qv);
    end
    if (!hit) chk({"timeout ", nm}, 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 12'h000;
    for (int i = 0; i < 32; i++) begin env_ram[i] = 8'h00; mram[i] = 8'h00; end
    env_ram[0] = 8'h04; mram[0] = 8'h04;
    env_ram[1] = 8'h03; mram[1] = 8'h03;
    env_ram[3] = 8'h01; mram[3] = 8'h01;
    rom[0]  = 12'h1C0; rom[1]  = 12'h421; rom[2]  = 12'hCF2; rom[3]  = 12'hA05;
    rom[5]  = 12'h703; rom[6]  = 12'hD0F; rom[7]  = 12'h403; rom[8]  = 12'h703;
    rom[9]  = 12'h603; rom[10] = 12'h000; rom[11] = 12'h900; rom[12] = 12'h024;
    rom[13] = 12'h1E4; rom[14] = 12'h040; rom[15] = 12'h041; rom[16] = 12'hFFF;
    rom[17] = 12'h065; rom[18] = 12'hBFF; rom[9'h1FF] = 12'h606;

    rst = 1'b1; en = 1'b0;
    tick(3);
    chk_en = 1'b1;
    chk("rst q", 32'(q_state), 32'd0);
    chk("rst pc", 32'(rom_addr), 32'd0);
    chk("rst ir", 32'(ir_reg_bus), 32'h000);
    chk("rst w", 32'(w_reg_bus), 32'h00);
    chk("rst we", 32'(ram_we), 32'd0);
    rst = 1'b0; en = 1'b1;
    tick(1);
    chk("fetch0 pc", 32'(rom_addr), 32'd1);
    chk("fetch0 ir", 32'(ir_reg_bus), 32'h1C0);
    tick(3);
    chk("addwf w", 32'(w_reg_bus), 32'h04);
    tick(3);
    chk("bcf we", 32'(ram_we), 32'd1);
    chk("bcf addr", 32'(ram_addr), 32'h01);
    chk("bcf data", 32'(ram_wr_data), 32'h01);
    chk("bcf w", 32'(w_reg_bus), 32'h04);
    tick(5);
    chk("movlw w", 32'(w_reg_bus), 32'hF2);
    tick(4);
    chk("goto pc", 32'(rom_addr), 32'd5);
    tick(4);
    chk("btfss skip pc", 32'(rom_addr), 32'd7);

    en = 1'b0;
    tick(10);
    chk("stall q", 32'(q_state), 32'd0);
    chk("stall pc", 32'(rom_addr), 32'd7);
    chk("stall w", 32'(w_reg_bus), 32'hF2);
    en = 1'b1;
    tick(2);
    chk("q3 reached", 32'(q_state), 32'd2);
    en = 1'b0;
    tick(4);
    chk("late stall q", 32'(q_state), 32'd0);
    chk("late stall pc", 32'(rom_addr), 32'd8);
    en = 1'b1;

    wait_for(12'h900, 2'd3, "illegal");
    chk("illegal pulse", 32'(illegal_op), 32'd1);
    chk("illegal no we", 32'(ram_we), 32'd0);
    chk("illegal pc", 32'(rom_addr), 32'd12);

    wait_for(12'h1E4, 2'd2, "addwf d1");
    rst = 1'b1;
    tick(1);
    chk("mid rst we", 32'(ram_we), 32'd0);
    chk("mid rst pc", 32'(rom_addr), 32'd0);
    chk("mid rst w", 32'(w_reg_bus), 32'd0);
    chk("mid rst ir", 32'(ir_reg_bus), 32'd0);
    chk("mid rst q", 32'(q_state), 32'd0);
    rst = 1'b0;

    wait_for(12'h606, 2'd1, "top fetch");
    chk("top wrap pc", 32'(rom_addr), 32'd0);
    wait_for(12'h606, 2'd3, "top skip");
    tick(1);
    chk("top skip pc", 32'(rom_addr), 32'd1);
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic10_ctrl_seq.md
Name: pic10_ctrl_seq

Overview:
- Instruction sequencer and writeback controller for the PIC10 datapath.
- It sits on the other end of the combinational ALU: it fetches 12-bit instructions from program ROM and drives ir_reg_bus and w_reg_bus into the ALU.
- It drives the RAM address, then consumes alu_bus to write back to W or to the RAM file.
- Every instruction runs in one 4-clock Q-cycle (Q1..Q4). There is no fetch pipeline.

Parameters:
- PC_W, 9, program counter / ROM address width.
- RESET_VEC, 9'h000, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; sampled only in Q1.
- rom_addr  out  PC_W  program address; equals pc.
- rom_data  in  12  instruction word; ROM is combinational.
- ir_reg_bus  out  12  instruction register, to ALU.
- w_reg_bus  out  8  W register, to ALU.
- ram_data_bus  in  8  RAM read data for address ram_addr.
- ram_addr  out  5  file address; equals ir_reg_bus[4:0].
- alu_bus  in  8  ALU result.
- ram_wr_data  out  8  equals alu_bus.
- ram_we  out  1  RAM write strobe.
- q_state  out  2  current Q phase, 0..3 = Q1..Q4.
- illegal_op  out  1  one-clock pulse on an unsupported opcode.

Behaviour:
- Reset (synchronous; wins over everything, including mid-instruction):
  - pc=RESET_VEC, ir=12'h000 (NOP), W=8'h00, q_state=0.
  - ram_we=0, illegal_op=0.
  - Any partially executed instruction is abandoned; no writeback occurs.
- Phase counter:
  - q_state advances 0->1->2->3->0 each clk.
  - Exception: in Q1 with en=0, q_state, pc, ir and W all hold. en is ignored in Q2..Q4.
- Q1 edge (q_state=0, en=1): ir <= rom_data; pc <= pc+1, wrapping at 2^PC_W.
- Q2/Q3: no state change. ALU settles on ir, W and ram_data_bus.
- Q4 edge (q_state=3): writeback and PC redirect, by ir decode.
  - Byte ops ir[11:10]=00, excluding MOVWF/CLRW/CLRF:
    - d=ir[5]=0: W <= alu_bus.
    - d=1: RAM write.
  - Fixed destinations:
    - MOVWF 0000_001f_ffff: RAM write.
    - CLRF 0000_011f_ffff: RAM write.
    - CLRW 0000_0100_0000: W <= alu_bus.
  - BCF 0100_bbbf_ffff and BSF 0101_bbbf_ffff: RAM write.
  - Skips, bit b=ir[7:5]:
    - BTFSC 0110: if ram_data_bus[b]==0 then pc <= pc+1.
    - BTFSS 0111: if ram_data_bus[b]==1 then pc <= pc+1.
    - No writeback in either case.
  - GOTO 101k_kkkk_kkkk: pc <= ir[8:0]. No writeback.
  - Literal ops MOVLW 1100 / IORLW 1101 / ANDLW 1110 / XORLW 1111: W <= alu_bus.
  - NOP 12'h000: nothing.
  - Unsupported opcodes (CALL 1001, RETLW 1000, 0000_0000_0xxx other than NOP, 0000_0100_0001..0000_0101_1111):
    - Executed as NOP.
    - illegal_op=1 during Q4 only.
- RAM write rule:
  - ram_we=1 combinationally while q_state=3 and the instruction writes RAM; otherwise 0.
  - The RAM captures ram_wr_data at the end of Q4.
- Skip/GOTO boundaries:
  - A skip of the instruction at the top address wraps pc to 0.
  - GOTO overrides the Q1 increment.
  - A skip adds exactly one to the already-incremented pc.
- Throughput and latency:
  - 4 clk per instruction, no bubbles.
  - The W update is visible on w_reg_bus the clk after the Q4 edge.

Test Plan:
- Reset then en=1, ROM[0]=12'h1C0 (ADDWF 0,d=0), W=0, ALU returns 8'h04 -> at Q4 edge W=8'h04, ram_we=0, pc=1 after Q1.
- ROM[1]=12'h421 (BCF f=1,b=1), alu_bus=8'h01 -> ram_we=1 only in Q4, ram_addr=5'h01, ram_wr_data=8'h01, W unchanged.
- ROM[2]=12'hCF2 (MOVLW 0xF2), alu_bus=8'hF2 -> W=8'hF2 after Q4; ROM[3]=12'hA05 (GOTO 5) -> next Q1 fetches rom_addr=5.
- BTFSS f=3,b=0 with ram_data_bus=8'h01 -> pc advances by 2 (e.g. 5->7); with 8'h00 -> pc advances by 1 (5->6).
- en=0 held for 10 clk in Q1 -> q_state stays 0, pc/ir/W frozen; en=0 asserted in Q3 -> instruction still completes, then stalls at Q1.
- rst pulsed during Q3 of a d=1 byte op -> ram_we never asserts; next cycle pc=0, W=0, ir=0, q_state=0. Opcode 12'h900 -> illegal_op pulses in Q4, no writes, pc+1.
